// File: rtl/spi_pkg.sv
// Shared definitions for the APB/FIFO front end of the SPI master.
// Holds the register index map, the low-power mode enum, status-register
// bit positions and the write masks for CR2 and BR.
package spi_pkg;

    // Register word indices on PADDR
    localparam logic [2:0] REG_CR1  = 3'd0;
    localparam logic [2:0] REG_CR2  = 3'd1;
    localparam logic [2:0] REG_BR   = 3'd2;
    localparam logic [2:0] REG_SR   = 3'd3;
    localparam logic [2:0] REG_FCR  = 3'd4;
    localparam logic [2:0] REG_DR   = 3'd5;
    localparam logic [2:0] REG_FLVL = 3'd6;

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        WAIT = 2'b01,
        STOP = 2'b10
    } spi_mode_e;

    // SR bit positions
    localparam int SR_SPIF   = 7;
    localparam int SR_OVR    = 6;
    localparam int SR_SPTEF  = 5;
    localparam int SR_MODF   = 4;
    localparam int SR_TXFULL = 3;

    // CR1 bit positions
    localparam int CR1_SPIE  = 7;
    localparam int CR1_SPE   = 6;
    localparam int CR1_SPTIE = 5;
    localparam int CR1_MSTR  = 4;
    localparam int CR1_CPOL  = 3;
    localparam int CR1_CPHA  = 2;
    localparam int CR1_SSOE  = 1;
    localparam int CR1_LSBFE = 0;

    // CR2 bit positions
    localparam int CR2_MODFEN  = 4;
    localparam int CR2_SPISWAI = 1;

    localparam logic [7:0] CR1_RESET = 8'h04;
    localparam logic [7:0] CR2_MASK  = 8'h1B;
    localparam logic [7:0] BR_MASK   = 8'h77;

endpackage

// File: rtl/apb_spi_fifo_if_if.sv
// APB slave bus bundle for the SPI FIFO register block.
// master modport: drives PSEL/PENABLE/PWRITE/PADDR/PWDATA, samples
//                 PRDATA/PREADY/PSLVERR.
// slave modport : the reverse.
interface apb_spi_fifo_if_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [2:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/spi_sync_fifo.sv
// Single-clock first-word-fall-through FIFO used for both SPI data paths.
// Ports:
//   clk, rst_n        clock, async active-low reset (empties the FIFO)
//   push, din         write request and data; ignored while full
//   pop               read request; ignored while empty
//   flush             empties the FIFO, overriding same-cycle push/pop
//   full, empty       decoded from the current count
//   count             fill level, 0..DEPTH
//   head              oldest entry, valid while not empty
module spi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Gating on the pre-edge count means a pop never makes room for a
    // same-cycle push into a full FIFO.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/apb_spi_fifo_if.sv
// APB register front end for the SPI master core with TX/RX FIFOs.
// Zero-wait-state APB slave (PREADY = PSEL & PENABLE); PSLVERR flags DR
// overflow/underflow and config writes during a transfer.
// Ports:
//   PCLK, PRESETn            clock, async active-low reset
//   apb (slave modport)      APB bus
//   mstr..spiswai, sppr/spr  CR1/CR2/BR decodes to the core
//   spi_mode                 RUN/WAIT/STOP low-power state
//   tx_valid/tx_data/tx_ready  TX FIFO head handshake to the core
//   rx_valid/rx_data         RX frames from the core (no back-pressure)
//   tip, ss                  transfer-in-progress, slave-select sense
//   spi_interrupt_request    level interrupt
// Build option: SPI_FIFO_THRESH_IRQ_EN adds RX/TX level thresholds in FCR
// that replace SPIF/SPTEF in the interrupt equation.
module apb_spi_fifo_if
    import spi_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    apb_spi_fifo_if_if.slave    apb,
    output logic                mstr,
    output logic                cpol,
    output logic                cpha,
    output logic                lsbfe,
    output logic                spiswai,
    output logic [2:0]          sppr,
    output logic [2:0]          spr,
    output logic [1:0]          spi_mode,
    output logic                tx_valid,
    output logic [DATA_W-1:0]   tx_data,
    input  logic                tx_ready,
    input  logic                rx_valid,
    input  logic [DATA_W-1:0]   rx_data,
    input  logic                tip,
    input  logic                ss,
    output logic                spi_interrupt_request
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              access, wr_acc, rd_acc;
    logic              cfg_sel, cfg_err, dr_wr, dr_rd, dr_wr_err, dr_rd_err, sr_rd;
    logic [7:0]        cr1, cr2, br, sr;
    logic              spie, spe, sptie, ssoe, modfen, modf, ovr;
    logic              tx_full, tx_empty, rx_full, rx_empty, tx_pop, tx_flush, rx_flush;
    logic [CNT_W-1:0]  tx_cnt, rx_cnt;
    logic [DATA_W-1:0] rx_head;
    logic              rx_irq_term, tx_irq_term;
    logic [31:0]       fcr_rdata, rdata;
    spi_mode_e         mode_q, mode_d;

    // ---------------- APB decode ----------------
    assign access = apb.PSEL & apb.PENABLE;
    assign wr_acc = access & apb.PWRITE;
    assign rd_acc = access & ~apb.PWRITE;
    assign apb.PREADY = access;

    assign cfg_sel   = (apb.PADDR == REG_CR1) | (apb.PADDR == REG_CR2) | (apb.PADDR == REG_BR);
    assign cfg_err   = wr_acc & cfg_sel & tip;
    assign dr_wr     = wr_acc & (apb.PADDR == REG_DR);
    assign dr_rd     = rd_acc & (apb.PADDR == REG_DR);
    assign dr_wr_err = dr_wr & tx_full;
    assign dr_rd_err = dr_rd & rx_empty;
    assign sr_rd     = rd_acc & (apb.PADDR == REG_SR);
    assign apb.PSLVERR = cfg_err | dr_wr_err | dr_rd_err;

    assign tx_flush = wr_acc & (apb.PADDR == REG_FCR) & apb.PWDATA[0];
    assign rx_flush = wr_acc & (apb.PADDR == REG_FCR) & apb.PWDATA[1];

    // ---------------- control registers ----------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cr1 <= CR1_RESET;
            cr2 <= '0;
            br  <= '0;
        end else if (wr_acc && !tip) begin
            case (apb.PADDR)
                REG_CR1: cr1 <= apb.PWDATA[7:0];
                REG_CR2: cr2 <= apb.PWDATA[7:0] & CR2_MASK;
                REG_BR:  br  <= apb.PWDATA[7:0] & BR_MASK;
                default: ;
            endcase
        end
    end

    assign spie    = cr1[CR1_SPIE];
    assign spe     = cr1[CR1_SPE];
    assign sptie   = cr1[CR1_SPTIE];
    assign mstr    = cr1[CR1_MSTR];
    assign cpol    = cr1[CR1_CPOL];
    assign cpha    = cr1[CR1_CPHA];
    assign ssoe    = cr1[CR1_SSOE];
    assign lsbfe   = cr1[CR1_LSBFE];
    assign modfen  = cr2[CR2_MODFEN];
    assign spiswai = cr2[CR2_SPISWAI];
    assign sppr    = br[6:4];
    assign spr     = br[2:0];

    // ---------------- FIFOs ----------------
    assign tx_pop = tx_ready & tx_valid;

    spi_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .push  (dr_wr),
        .pop   (tx_pop),
        .flush (tx_flush),
        .din   (apb.PWDATA[DATA_W-1:0]),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_cnt),
        .head  (tx_data)
    );

    spi_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .push  (rx_valid),
        .pop   (dr_rd),
        .flush (rx_flush),
        .din   (rx_data),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_cnt),
        .head  (rx_head)
    );

    // Overrun is sticky; a frame lost in the same cycle as the SR read
    // must survive, so the set term has priority over the read-clear.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)                 ovr <= 1'b0;
        else if (rx_valid && rx_full) ovr <= 1'b1;
        else if (sr_rd)               ovr <= 1'b0;
    end

    // ---------------- mode FSM ----------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) mode_q <= RUN;
        else          mode_q <= mode_d;
    end

    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            RUN:     if (!spe) mode_d = WAIT;
            WAIT:    if (spe) mode_d = RUN;
                     else if (spiswai) mode_d = STOP;
            STOP:    if (!spiswai) mode_d = WAIT;
            default: mode_d = RUN;
        endcase
    end

    assign spi_mode = mode_q;
    assign tx_valid = ~tx_empty & (mode_q != STOP);

    // ---------------- status / interrupt ----------------
    assign modf = mstr & ~ss & ssoe & ~modfen;

    always_comb begin
        sr            = '0;
        sr[SR_SPIF]   = ~rx_empty;
        sr[SR_OVR]    = ovr;
        sr[SR_SPTEF]  = tx_empty;
        sr[SR_MODF]   = modf;
        sr[SR_TXFULL] = tx_full;
    end

`ifdef SPI_FIFO_THRESH_IRQ_EN
    logic [2:0] rxth, txth;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rxth <= '0;
            txth <= '0;
        end else if (wr_acc && apb.PADDR == REG_FCR) begin
            rxth <= apb.PWDATA[6:4];
            txth <= apb.PWDATA[10:8];
        end
    end

    // int casts keep the compare correct when CNT_W is narrower than 3
    assign rx_irq_term = int'(rx_cnt) > int'(rxth);
    assign tx_irq_term = int'(tx_cnt) <= int'(txth);
    assign fcr_rdata   = {21'b0, txth, 1'b0, rxth, 4'b0};
`else
    assign rx_irq_term = ~rx_empty;
    assign tx_irq_term = tx_empty;
    assign fcr_rdata   = '0;
`endif

    assign spi_interrupt_request = (spie & (rx_irq_term | ovr | modf)) | (sptie & tx_irq_term);

    // ---------------- read mux ----------------
    always_comb begin
        rdata = '0;
        if (rd_acc) begin
            case (apb.PADDR)
                REG_CR1:  rdata[7:0] = cr1;
                REG_CR2:  rdata[7:0] = cr2;
                REG_BR:   rdata[7:0] = br;
                REG_SR:   rdata[7:0] = sr;
                REG_FCR:  rdata      = fcr_rdata;
                REG_DR:   if (!rx_empty) rdata[DATA_W-1:0] = rx_head;
                REG_FLVL: begin
                    rdata[8 +: CNT_W] = rx_cnt;
                    rdata[0 +: CNT_W] = tx_cnt;
                end
                default:  ;
            endcase
        end
    end

    assign apb.PRDATA = rdata;

endmodule

// File: tb/tb_apb_spi_fifo_if.sv
// Self-checking bench for apb_spi_fifo_if: directed scenarios followed by
// randomized APB/core traffic scored against a queue-based model.
module tb_apb_spi_fifo_if;
    import spi_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic              PCLK = 1'b0;
    logic              PRESETn = 1'b0;
    logic              mstr, cpol, cpha, lsbfe, spiswai;
    logic [2:0]        sppr, spr;
    logic [1:0]        spi_mode;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready = 1'b0;
    logic              rx_valid = 1'b0;
    logic [DATA_W-1:0] rx_data = '0;
    logic              tip = 1'b0;
    logic              ss = 1'b1;
    logic              irq;

    apb_spi_fifo_if_if bus ();

    apb_spi_fifo_if #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
        .PCLK                  (PCLK),
        .PRESETn               (PRESETn),
        .apb                   (bus),
        .mstr                  (mstr),
        .cpol                  (cpol),
        .cpha                  (cpha),
        .lsbfe                 (lsbfe),
        .spiswai               (spiswai),
        .sppr                  (sppr),
        .spr                   (spr),
        .spi_mode              (spi_mode),
        .tx_valid              (tx_valid),
        .tx_data               (tx_data),
        .tx_ready              (tx_ready),
        .rx_valid              (rx_valid),
        .rx_data               (rx_data),
        .tip                   (tip),
        .ss                    (ss),
        .spi_interrupt_request (irq)
    );

    always #5 PCLK = ~PCLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    bit         m_ovr;

    function automatic logic [7:0] sr_model();
        return {rxq.size() != 0, m_ovr, txq.size() == 0, 1'b0, txq.size() == DEPTH, 3'b000};
    endfunction

    // One APB transfer; core handshakes (tx_ready/rx_valid) optionally ride
    // on the ACCESS cycle. All outputs are sampled mid-ACCESS at negedge.
    task automatic xfer(input bit w, input logic [2:0] a, input logic [31:0] d,
                        input bit txr, input bit rxv, input logic [7:0] rxd,
                        output logic [31:0] rdat, output bit err, output bit txv,
                        output logic [7:0] txd, output bit irq_o);
        @(posedge PCLK); #1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = w; bus.PADDR = a; bus.PWDATA = d;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1; tx_ready = txr; rx_valid = rxv; rx_data = rxd;
        @(negedge PCLK);
        chk("pready", bus.PREADY, 32'd1);
        rdat = bus.PRDATA; err = bus.PSLVERR; txv = tx_valid; txd = tx_data; irq_o = irq;
        @(posedge PCLK); #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
    endtask

    task automatic apb_wr(input logic [2:0] a, input logic [31:0] d, output bit err);
        logic [31:0] r; bit tv, iq; logic [7:0] td;
        xfer(1'b1, a, d, 1'b0, 1'b0, 8'h00, r, err, tv, td, iq);
    endtask

    task automatic apb_rd(input logic [2:0] a, output logic [31:0] r, output bit err);
        bit tv, iq; logic [7:0] td;
        xfer(1'b0, a, 32'h0, 1'b0, 1'b0, 8'h00, r, err, tv, td, iq);
    endtask

    task automatic rx_push(input logic [7:0] v);
        logic [31:0] r; bit e, tv, iq; logic [7:0] td;
        xfer(1'b0, 3'd7, 32'h0, 1'b0, 1'b1, v, r, e, tv, td, iq);
    endtask

    task automatic mode_chk(input string tag, input logic [1:0] exp);
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        chk(tag, spi_mode, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        bit          e;
        logic [7:0]  tx_seq [4];
        bit          w, txr, rxv, e_err, e_txv, e_irq, o_txv, o_irq;
        logic [2:0]  a;
        logic [31:0] d, e_rd;
        logic [7:0]  rxd, o_txd;
        int          op;
        bit          txp, txpop, rxp, rxpop, ovf;

        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = '0; bus.PWDATA = '0;

        // ---- reset state ----
        #2;
        chk("rst_prdata", bus.PRDATA, 32'h0);
        chk("rst_pslverr", bus.PSLVERR, 32'h0);
        chk("rst_tx_valid", tx_valid, 32'h0);
        chk("rst_mode", spi_mode, 32'h0);
        chk("rst_irq", irq, 32'h0);
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        apb_rd(REG_SR, r, e);   chk("rst_sr", r, 32'h20);
        apb_rd(REG_CR1, r, e);  chk("rst_cr1", r, 32'h04);
        apb_rd(REG_FLVL, r, e); chk("rst_flvl", r, 32'h0);

        // ---- TX fill to full, overflow write ----
        tx_seq[0] = 8'hA1; tx_seq[1] = 8'hB2; tx_seq[2] = 8'hC3; tx_seq[3] = 8'hD4;
        for (int i = 0; i < 4; i++) begin
            apb_wr(REG_DR, {24'h0, tx_seq[i]}, e);
            chk("tx_fill_err", e, 32'h0);
        end
        apb_rd(REG_SR, r, e);   chk("tx_full_sr", r, 32'h08);
        apb_wr(REG_DR, 32'hEE, e); chk("tx_ovf_err", e, 32'h1);
        apb_rd(REG_FLVL, r, e); chk("tx_ovf_flvl", r, 32'h004);

        // ---- TX drain with tx_ready held ----
        @(posedge PCLK); #1;
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            chk("drain_valid", tx_valid, 32'h1);
            chk("drain_data", tx_data, tx_seq[i]);
            @(posedge PCLK); #1;
        end
        @(negedge PCLK);
        chk("drain_done", tx_valid, 32'h0);
        tx_ready = 1'b0;
        apb_rd(REG_SR, r, e); chk("drain_sr", r, 32'h20);

        // ---- RX overrun, reads, underflow ----
        for (int i = 0; i < 5; i++) rx_push(8'h11 + 8'(i));
        apb_rd(REG_SR, r, e); chk("rx_ovr_sr", r, 32'hE0);
        for (int i = 0; i < 4; i++) begin
            apb_rd(REG_DR, r, e);
            chk("rx_read", r, 32'h11 + 32'(i));
            chk("rx_read_err", e, 32'h0);
        end
        apb_rd(REG_DR, r, e);
        chk("rx_empty_err", e, 32'h1);
        chk("rx_empty_data", r, 32'h0);
        apb_rd(REG_SR, r, e); chk("ovr_cleared", r, 32'h20);

        // ---- config write blocked during a transfer ----
        tip = 1'b1;
        apb_wr(REG_CR1, 32'h50, e); chk("tip_err", e, 32'h1);
        tip = 1'b0;
        apb_rd(REG_CR1, r, e); chk("tip_cr1", r, 32'h04);

        // ---- mode FSM ----
        apb_wr(REG_CR1, 32'h40, e); mode_chk("mode_run", 2'b00);
        apb_wr(REG_CR1, 32'h00, e); mode_chk("mode_wait", 2'b01);
        apb_wr(REG_DR, 32'h5A, e);
        @(negedge PCLK); chk("wait_txv", tx_valid, 32'h1);
        apb_wr(REG_CR2, 32'h02, e); mode_chk("mode_stop", 2'b10);
        chk("stop_txv", tx_valid, 32'h0);
        chk("spiswai", spiswai, 32'h1);
        rx_push(8'h66);
        apb_rd(REG_FLVL, r, e); chk("stop_flvl", r, 32'h101);
        apb_rd(REG_DR, r, e);   chk("stop_rx", r, 32'h66);
        apb_wr(REG_CR2, 32'hFF, e);
        apb_rd(REG_CR2, r, e);  chk("cr2_mask", r, 32'h1B);
        apb_wr(REG_BR, 32'hFF, e);
        apb_rd(REG_BR, r, e);   chk("br_mask", r, 32'h77);
        chk("sppr_spr", {sppr, spr}, 32'h3F);
        apb_wr(REG_CR2, 32'h00, e); mode_chk("mode_unstop", 2'b01);
        chk("unstop_txv", tx_valid, 32'h1);
        apb_wr(REG_FCR, 32'h01, e);
        chk("flush_txv", tx_valid, 32'h0);
        apb_rd(REG_FCR, r, e); chk("fcr_read", r, 32'h0);

        // ---- interrupt thresholds ----
        apb_wr(REG_CR1, 32'h80, e);
        chk("irq_idle", irq, 32'h0);
`ifdef SPI_FIFO_THRESH_IRQ_EN
        apb_wr(REG_FCR, 32'h20, e);
        apb_rd(REG_FCR, r, e); chk("fcr_rxth", r, 32'h20);
        rx_push(8'h01); chk("th_irq1", irq, 32'h0);
        rx_push(8'h02); chk("th_irq2", irq, 32'h0);
        rx_push(8'h03); chk("th_irq3", irq, 32'h1);
        apb_wr(REG_FCR, 32'h22, e); chk("th_flush", irq, 32'h0);
`else
        apb_wr(REG_FCR, 32'h720, e);
        apb_rd(REG_FCR, r, e); chk("fcr_noth", r, 32'h0);
        rx_push(8'h01); chk("spif_irq", irq, 32'h1);
        apb_wr(REG_FCR, 32'h02, e); chk("spif_flush", irq, 32'h0);
`endif

        // ---- reset mid-traffic ----
        apb_wr(REG_DR, 32'h33, e);
        rx_push(8'h44);
        apb_rd(REG_FLVL, r, e); chk("pre_rst_flvl", r, 32'h101);
        @(negedge PCLK); #1 PRESETn = 1'b0;
        #1;
        chk("midrst_txv", tx_valid, 32'h0);
        chk("midrst_mode", spi_mode, 32'h0);
        @(posedge PCLK); #1 PRESETn = 1'b1;
        apb_rd(REG_FLVL, r, e); chk("post_rst_flvl", r, 32'h0);
        apb_rd(REG_SR, r, e);   chk("post_rst_sr", r, 32'h20);

        // ---- randomized traffic vs model ----
        apb_wr(REG_CR1, 32'hF0, e);
        mode_chk("rnd_mode", 2'b00);
        txq.delete(); rxq.delete(); m_ovr = 1'b0;
        for (int it = 0; it < 400; it++) begin
            w = 1'b0; a = 3'd7; d = 32'h0;
            op = $urandom_range(0, 5);
            case (op)
                0, 1: begin w = 1'b1; a = REG_DR; d = $urandom; end
                2:    a = REG_DR;
                3:    a = REG_SR;
                4:    a = REG_FLVL;
                default: if ($urandom_range(0, 3) == 0) begin
                    w = 1'b1; a = REG_FCR; d = $urandom_range(1, 3);
                end
            endcase
            txr = 1'($urandom_range(0, 1));
            rxv = ($urandom_range(0, 9) < 4);
            rxd = 8'($urandom);

            e_err = w ? (a == REG_DR && txq.size() == DEPTH) : (a == REG_DR && rxq.size() == 0);
            e_rd = 32'h0;
            if (!w) begin
                case (a)
                    REG_DR:   if (rxq.size() != 0) e_rd = {24'h0, rxq[0]};
                    REG_SR:   e_rd = {24'h0, sr_model()};
                    REG_FLVL: e_rd = 32'((rxq.size() << 8) | txq.size());
                    default:  e_rd = 32'h0;
                endcase
            end
            e_txv = (txq.size() != 0);
            e_irq = (rxq.size() != 0) || m_ovr || (txq.size() == 0);

            xfer(w, a, d, txr, rxv, rxd, r, e, o_txv, o_txd, o_irq);
            chk("rnd_rdata", r, e_rd);
            chk("rnd_err", e, e_err);
            chk("rnd_txv", o_txv, e_txv);
            chk("rnd_irq", o_irq, e_irq);
            if (e_txv) chk("rnd_txd", o_txd, txq[0]);

            // TX side
            txp   = w && a == REG_DR && txq.size() < DEPTH;
            txpop = txr && txq.size() != 0;
            if (w && a == REG_FCR && d[0]) txq.delete();
            else begin
                if (txpop) void'(txq.pop_front());
                if (txp)   txq.push_back(d[7:0]);
            end
            // RX side
            ovf   = rxv && rxq.size() == DEPTH;
            rxp   = rxv && rxq.size() < DEPTH;
            rxpop = !w && a == REG_DR && rxq.size() != 0;
            if (w && a == REG_FCR && d[1]) rxq.delete();
            else begin
                if (rxpop) void'(rxq.pop_front());
                if (rxp)   rxq.push_back(rxd);
            end
            if (ovf) m_ovr = 1'b1;
            else if (!w && a == REG_SR) m_ovr = 1'b0;
        end
        apb_rd(REG_FLVL, r, e);
        chk("rnd_final_flvl", r, 32'((rxq.size() << 8) | txq.size()));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_spi_fifo_if.md
# apb_spi_fifo_if

Second-generation APB register interface for the SPI master core: parametrised data width, TX and RX FIFOs, sticky error and overrun reporting, and PSLVERR generation. It sits between the APB bus and the SPI shift/baud engine. It replaces the single-entry data register with FIFO-backed streaming and a valid/ready handshake to the core.

## Interface
- DATA_W, 8, SPI frame width in bits; legal values 8 or 16.
- FIFO_DEPTH, 4, entries per FIFO; power of two, 2..16.
- CNT_W, $clog2(FIFO_DEPTH)+1, width of the FIFO level counters; derived, not overridden.
- PCLK  in  1  APB clock; the only clock of the block.
- PRESETn  in  1  asynchronous, active-low reset.
- PSEL, PENABLE, PWRITE  in  1 each  APB control.
- PADDR  in  3  word register index.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data; 0 outside a read ACCESS cycle.
- PREADY  out  1  transfer-ready indication.
- PSLVERR  out  1  transfer-error indication.
- mstr, cpol, cpha, lsbfe, spiswai  out  1 each  CR1/CR2 decodes to the core.
- sppr, spr  out  3 each  baud prescaler and rate selects.
- spi_mode  out  2  00 RUN, 01 WAIT, 10 STOP.
- tx_valid  out  1  TX FIFO non-empty and mode is not STOP.
- tx_data  out  DATA_W  TX FIFO head.
- tx_ready  in  1  core pops the TX head this cycle.
- rx_valid  in  1  core pushes a received frame.
- rx_data  in  DATA_W  received frame.
- tip, ss  in  1 each  transfer in progress; slave-select sense.
- spi_interrupt_request  out  1  level interrupt.

## Operation
- APB: zero wait states. PREADY = PSEL & PENABLE. Writes and DR pops commit on the ACCESS edge.
- Register map (index: register):
  - 0 CR1, reset 0x04.
  - 1 CR2, masked 0x1B.
  - 2 BR, masked 0x77.
  - 3 SR, read-only.
  - 4 FCR.
  - 5 DR.
  - 6 FLVL, read-only: {rx_cnt at [12:8], tx_cnt at [4:0]}.
  - 7 reads 0; writes to it are ignored.
- DR write pushes PWDATA[DATA_W-1:0] into the TX FIFO. DR read returns the RX head and pops it.
- FCR bits:
  - [0] TX flush, write-1, self-clearing, reads 0.
  - [1] RX flush, same behaviour as [0].
  - Remaining fields are described under Configuration.
- SR bits:
  - [7] SPIF: RX non-empty.
  - [6] OVR: sticky; cleared by an SR read.
  - [5] SPTEF: TX empty.
  - [4] MODF: mstr & ~ss & ssoe & ~modfen.
  - [3] TXFULL.
  - [2:0] read 0.
- PSLVERR is asserted in the ACCESS cycle for any of these; the offending access has no effect:
  - DR write while TX full.
  - DR read while RX empty; PRDATA returns 0.
  - Write to CR1, CR2 or BR while tip = 1.
- Mode FSM:
  - RUN -> WAIT when spe = 0.
  - WAIT -> RUN when spe = 1.
  - WAIT -> STOP when spiswai = 1.
  - STOP -> WAIT when spiswai = 0.
  - In STOP, tx_valid is forced to 0; RX pushes are still accepted.
- RX push while RX full: the frame is dropped and OVR is set.
- Full and empty are evaluated on the current count. A same-cycle pop never admits a push into a full FIFO.
- Simultaneous push and pop on a non-full, non-empty FIFO: count is unchanged and both take effect.
- A flush overrides any same-cycle push or pop on that FIFO; count becomes 0.
- OVR set and an SR-read clear in the same cycle: set wins.
- Interrupt: spi_interrupt_request = spie & (SPIF | OVR | MODF) | sptie & SPTEF.

## Timing
- Reset values:
  - PRDATA 0, PSLVERR 0, tx_valid 0, spi_mode 00, spi_interrupt_request 0.
  - Both FIFOs empty; SR = 0x20.
- Register write: the register, and every decode derived from it, updates on the ACCESS edge and is visible the next cycle.
- TX latency: DR write at edge N gives tx_valid = 1 from cycle N+1.
- RX latency: rx_valid at edge N gives SPIF = 1 from cycle N+1.
- tx_data and PRDATA for DR are combinational from the FIFO head; first-word fall-through.
- SR and the interrupt are combinational from registered state.
- Reset asserted mid-transfer empties both FIFOs immediately, with no handshake to the core.

## Configuration
- SPI_FIFO_THRESH_IRQ_EN defined:
  - FCR[6:4] holds RXTH and FCR[10:8] holds TXTH.
  - SPIF in the interrupt term is replaced by rx_cnt > RXTH.
  - SPTEF in the interrupt term is replaced by tx_cnt <= TXTH.
  - SR bit meanings are unchanged.
- Undefined: the threshold bits read 0, writes to them are ignored, and the interrupt uses the plain SPIF/SPTEF terms.

## Structure
- Shared package spi_pkg holds:
  - Register index constants.
  - The spi_mode_e enum (RUN, WAIT, STOP).
  - SR bit positions.
  - CR2 and BR mask constants.
- Sub-module spi_sync_fifo(WIDTH, DEPTH), instantiated twice (TX and RX):
  - Ports: push, pop, flush, full, empty, count, head.
  - No internal PSLVERR logic.

## Test plan
- Write DR 0xA1, 0xB2, 0xC3, 0xD4 with DEPTH 4 -> TXFULL = 1. A fifth write -> PSLVERR = 1 and FLVL tx_cnt stays 4.
- Hold tx_ready = 1 -> tx_data sequence A1, B2, C3, D4; tx_valid drops the cycle after the 4th pop; SPTEF = 1.
- Five rx_valid pushes (0x11..0x15) -> OVR = 1. DR reads return 11..14; a fifth read gives PSLVERR = 1 with PRDATA = 0. An SR read clears OVR.
- Write CR1 = 0x50 while tip = 1 -> PSLVERR = 1 and CR1 stays 0x04.
- Write CR1 spe = 0, then CR2 = 0x02 -> spi_mode goes 01 then 10. With TX non-empty, tx_valid = 0 in STOP.
- With SPI_FIFO_THRESH_IRQ_EN, set spie = 1, RXTH = 2 -> the interrupt rises only on the 3rd RX push. Flush RX -> the interrupt drops the next cycle.
